lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 139 +++++++++++++
 tb/tb_lsu_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between a datapath and a 16-bit data memory.
// Word and byte loads (optional sign extension), word stores, and byte stores
// done as read-modify-write. Memory read data arrives one cycle after MemRd.
// Optional build macro LSU_BOUNDS_CHECK_EN: effective addresses above MEM_TOP
// complete immediately with err and no memory strobe.
//
// state | meaning
// IDLE  | waiting for start; request operands latched on accept
// RD    | MemRd asserted at the latched address
// RDW   | memory read data valid; load result or RMW merge captured
// WR    | MemWr asserted with mem_din at the latched address
// DONE  | one-cycle completion pulse, err qualifies it
module lsu_ctrl #(
  parameter int              AW      = 16,
  parameter int              DW      = 16,
  parameter logic [AW-1:0]   MEM_TOP = 16'h00FF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          op_ld,
  input  logic          op_st,
  input  logic          op_byte,
  input  logic          op_sext,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] offset,
  input  logic [DW-1:0] st_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          MemRd,
  output logic          MemWr,
  input  logic [DW-1:0] mem_dout,
  output logic [DW-1:0] ld_data,
  output logic          done,
  output logic          busy,
  output logic          err
);

`ifdef LSU_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ea_q;
  logic [DW-1:0] din_q;
  logic [DW-1:0] ld_q;
  logic          byte_q;
  logic          sext_q;
  logic          is_ld_q;
  logic          err_q;

  logic [AW-1:0] ea_sum;
  logic          req_err;
  logic [7:0]    rd_byte;

  assign ea_sum  = base + offset;
  // An invalid op encoding always errors; out-of-range only when bounds are built in.
  assign req_err = (op_ld == op_st) | (BOUNDS_EN & (ea_sum > MEM_TOP));
  assign rd_byte = mem_dout[7:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (req_err)               state_d = DONE;
          else if (op_ld || op_byte) state_d = RD;
          else                       state_d = WR;
        end
      end
      RD:      state_d = RDW;
      RDW:     state_d = is_ld_q ? DONE : WR;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, load-result capture and read-modify-write merge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_q    <= '0;
      din_q   <= '0;
      ld_q    <= '0;
      byte_q  <= 1'b0;
      sext_q  <= 1'b0;
      is_ld_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            ea_q    <= ea_sum;
            din_q   <= st_data;
            byte_q  <= op_byte;
            sext_q  <= op_sext;
            is_ld_q <= op_ld;
            err_q   <= req_err;
          end
        end
        RDW: begin
          if (is_ld_q) begin
            if (byte_q)
              ld_q <= {{(DW-8){sext_q & rd_byte[7]}}, rd_byte};
            else
              ld_q <= mem_dout;
          end else begin
            // Byte store keeps the upper byte already in memory.
            din_q <= {mem_dout[DW-1:8], din_q[7:0]};
          end
        end
        DONE:    err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state or taken straight from registers.
  assign MemRd    = (state_q == RD);
  assign MemWr    = (state_q == WR);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err      = (state_q == DONE) & err_q;
  assign mem_addr = (state_q == RD || state_q == WR) ? ea_q : '0;
  assign mem_din  = din_q;
  assign ld_data  = ld_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-addressed little-endian memory model, directed
// operations, and a negedge monitor that pops expected memory strobes and
// completion responses from queues filled by the stimulus process.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, op_ld, op_st, op_byte, op_sext;
  logic [15:0] base, offset, st_data;
  logic [15:0] mem_addr, mem_din, mem_dout, ld_data;
  logic        MemRd, MemWr, done, busy, err;

  lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_ld(op_ld), .op_st(op_st),
    .op_byte(op_byte), .op_sext(op_sext), .base(base), .offset(offset),
    .st_data(st_data), .mem_addr(mem_addr), .mem_din(mem_din), .MemRd(MemRd),
    .MemWr(MemWr), .mem_dout(mem_dout), .ld_data(ld_data), .done(done),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];

  // Memory: read data registered one cycle after MemRd, writes on MemWr edge.
  always @(posedge clk) begin
    if (MemRd) mem_dout <= {mem[mem_addr + 16'd1], mem[mem_addr]};
    if (MemWr) begin
      mem[mem_addr]         <= mem_din[7:0];
      mem[mem_addr + 16'd1] <= mem_din[15:8];
    end
  end

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
  } strobe_t;

  typedef struct packed {
    logic        err;
    logic [15:0] ld;
  } resp_t;

  strobe_t strobe_q[$];
  resp_t   resp_q[$];
  int      checks = 0;
  int      errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe and every completion must match the next expectation.
  always @(negedge clk) begin
    if (done) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        chk("resp_err", {31'd0, err}, {31'd0, r.err});
        chk("resp_ld_data", {16'd0, ld_data}, {16'd0, r.ld});
      end
    end
    if (MemRd || MemWr) begin
      chk("strobe_exclusive", {31'd0, MemRd & MemWr}, 32'd0);
      if (strobe_q.size() == 0) begin
        chk("unexpected_strobe", {15'd0, MemWr, mem_addr}, 32'd0);
      end else begin
        strobe_t s;
        s = strobe_q.pop_front();
        chk("strobe_kind", {31'd0, MemWr}, {31'd0, s.wr});
        chk("strobe_addr", {16'd0, mem_addr}, {16'd0, s.addr});
        if (s.wr) chk("strobe_din", {16'd0, mem_din}, {16'd0, s.din});
      end
    end
  end

  task automatic issue(input logic ld, input logic st, input logic byt, input logic sx,
                       input logic [15:0] b, input logic [15:0] o, input logic [15:0] d);
    op_ld = ld; op_st = st; op_byte = byt; op_sext = sx;
    base = b; offset = o; st_data = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic push_rd(input logic [15:0] a);
    strobe_q.push_back('{wr: 1'b0, addr: a, din: 16'h0000});
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    strobe_q.push_back('{wr: 1'b1, addr: a, din: d});
  endtask

  task automatic push_resp(input logic e, input logic [15:0] l);
    resp_q.push_back('{err: e, ld: l});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst_n = 1'b0; start = 1'b0; op_ld = 1'b0; op_st = 1'b0; op_byte = 1'b0;
    op_sext = 1'b0; base = '0; offset = '0; st_data = '0;
    mem[17] = 8'd7; mem[18] = 8'd32; mem[3] = 8'hF0;
    mem[16'h0100] = 8'h5A; mem[16'h0101] = 8'h3C;
    repeat (3) @(posedge clk); #1;

    chk("rst_busy",     {31'd0, busy},  32'd0);
    chk("rst_done",     {31'd0, done},  32'd0);
    chk("rst_err",      {31'd0, err},   32'd0);
    chk("rst_memrd",    {31'd0, MemRd}, 32'd0);
    chk("rst_memwr",    {31'd0, MemWr}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_din",  {16'd0, mem_din},  32'd0);
    chk("rst_ld_data",  {16'd0, ld_data},  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word load at 17 with latency check.
    push_rd(16'd17); push_resp(1'b0, 16'h2007);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 16'd16, 16'd1, 16'h0000);
    chk("wl_busy_rd", {31'd0, busy}, 32'd1);
    chk("wl_done_c2", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("wl_done_c3", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("wl_done_c4", {31'd0, done}, 32'd1);
    wait_idle("wl");

    // Byte loads at 3, signed then unsigned.
    push_rd(16'd3); push_resp(1'b0, 16'hFFF0);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 16'd3, 16'd0, 16'h0000);
    wait_idle("bl_sext");
    push_rd(16'd3); push_resp(1'b0, 16'h00F0);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 16'd3, 16'd0, 16'h0000);
    wait_idle("bl_zext");

    // Byte store read-modify-write at 2; ld_data untouched.
    mem[2] = 8'd9; mem[3] = 8'd10;
    push_rd(16'd2); push_wr(16'd2, 16'h0ACD); push_resp(1'b0, 16'h00F0);
    issue(1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 16'd0, 16'hABCD);
    wait_idle("bs");
    chk("bs_mem2", {24'd0, mem[2]}, 32'h0000_00CD);
    chk("bs_mem3", {24'd0, mem[3]}, 32'h0000_000A);

    // Word store at 4 with a second start while busy, then load it back.
    push_wr(16'd4, 16'h1234); push_resp(1'b0, 16'h00F0);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd4, 16'h1234);
    op_ld = 1'b1; op_st = 1'b0; base = 16'd17; offset = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("ws");
    @(posedge clk); #1;
    chk("ws_ignored_start", {31'd0, busy}, 32'd0);
    push_rd(16'd4); push_resp(1'b0, 16'h1234);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 16'd0, 16'h0000);
    wait_idle("wl4");

    // Invalid op encodings: completion with err, no strobes.
    push_resp(1'b1, 16'h1234);
    issue(1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 16'd0, 16'h0000);
    chk("bad_op_done", {31'd0, done}, 32'd1);
    wait_idle("bad_op11");
    chk("err_cleared", {31'd0, err}, 32'd0);
    push_resp(1'b1, 16'h1234);
    issue(1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 16'd0, 16'h0000);
    wait_idle("bad_op00");

    // Address wraps modulo 2^16: 0xFFFF + 3 = 2.
    push_rd(16'd2); push_resp(1'b0, 16'h0ACD);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'd3, 16'h0000);
    wait_idle("wrap");

    // Load just past MEM_TOP.
`ifdef LSU_BOUNDS_CHECK_EN
    push_resp(1'b1, 16'h0ACD);
`else
    push_rd(16'h0100); push_resp(1'b0, 16'h3C5A);
`endif
    issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 16'd0, 16'h0000);
    wait_idle("bounds");

    // Reset during the write phase of a byte store.
    mem[6] = 8'h11; mem[7] = 8'h22;
    push_rd(16'd6);
    issue(1'b0, 1'b1, 1'b1, 1'b0, 16'd6, 16'd0, 16'h00EE);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rmw_wr_phase", {31'd0, MemWr}, 32'd1);
    chk("rmw_wr_din", {16'd0, mem_din}, 32'h0000_22EE);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_memwr",   {31'd0, MemWr}, 32'd0);
    chk("mid_rst_busy",    {31'd0, busy},  32'd0);
    chk("mid_rst_addr",    {16'd0, mem_addr}, 32'd0);
    chk("mid_rst_din",     {16'd0, mem_din},  32'd0);
    chk("mid_rst_ld_data", {16'd0, ld_data},  32'd0);
    @(posedge clk); #1;
    chk("mid_rst_mem6", {24'd0, mem[6]}, 32'h0000_0011);
    rst_n = 1'b1;

    // First edge after reset release accepts a start.
    push_rd(16'd17); push_resp(1'b0, 16'h2007);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 16'd16, 16'd1, 16'h0000);
    chk("post_rst_accept", {31'd0, busy}, 32'd1);
    wait_idle("post_rst");

    repeat (2) @(posedge clk); #1;
    chk("strobes_left", strobe_q.size(), 32'd0);
    chk("resps_left", resp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
